// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: FSM states, bus owner, and
// access size codes, plus the width helper for the fairness counter.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } arb_owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Counter must hold FAIR_LIMIT itself and is never narrower than 3 bits.
    function automatic int fair_cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 3) begin
            w = 3;
        end
        return w;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_fair_cnt.sv
// Fairness counter for the SRAM bus arbiter. Counts data grants issued while
// the fetch side is waiting; once it reaches FAIR_LIMIT the fetch side is
// forced through on the next grant. Only built when ARB_FAIR_EN is defined.
module arb_fair_cnt
    import sram_bus_arbiter_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_data,
    input  logic grant_inst,
    input  logic inst_req,
    output logic force_inst
);

    localparam int CNT_W = fair_cnt_width(FAIR_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(FAIR_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating count of data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (grant_inst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (grant_data && inst_req && (cnt_r != LIMIT_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign force_inst = inst_req && (cnt_r == LIMIT_C);

endmodule

// File: rtl/sram_bus_arbiter.sv
// SRAM bus arbiter: multiplexes a fetch port and a load/store port onto one
// shared SRAM-like bus with at most one transaction outstanding. Data side
// has priority; with macro ARB_FAIR_EN defined, a fairness counter forces the
// fetch side through after FAIR_LIMIT consecutive bypassing data grants.
// Bus-side request fields and requester handshakes are decoded directly from
// the registered state/owner so that addr_ok and data_ok follow the bus in
// the same cycle.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_e state_r;
    arb_owner_e owner_r;
    logic       grant_inst_s;
    logic       grant_data_s;
    logic       force_inst_s;

`ifdef ARB_FAIR_EN
    arb_fair_cnt #(
        .FAIR_LIMIT (FAIR_LIMIT)
    ) u_fair_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .grant_data (grant_data_s),
        .grant_inst (grant_inst_s),
        .inst_req   (inst_req),
        .force_inst (force_inst_s)
    );
`else
    logic unused_fair_limit_s;
    assign unused_fair_limit_s = (FAIR_LIMIT > 0);
    assign force_inst_s = 1'b0;
`endif

    // Grant decision, only meaningful while idle: forced fetch, then data, then fetch.
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (state_r == IDLE) begin
            if (force_inst_s) begin
                grant_inst_s = 1'b1;
            end else if (data_req) begin
                grant_data_s = 1'b1;
            end else if (inst_req) begin
                grant_inst_s = 1'b1;
            end else begin
                grant_inst_s = 1'b0;
            end
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // Transaction FSM: latch owner on grant, wait for address accept, then data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            owner_r <= INST;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_data_s) begin
                        owner_r <= DATA;
                        state_r <= ADDR;
                    end else if (grant_inst_s) begin
                        owner_r <= INST;
                        state_r <= ADDR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    owner_r <= INST;
                end
            endcase
        end
    end

    // Route bus request fields and handshakes between the owner and the bus.
    always_comb begin
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = SIZE_BYTE;
        bus_addr     = 32'h0000_0000;
        bus_wdata    = 32'h0000_0000;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0000_0000;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0000_0000;
        case (state_r)
            ADDR: begin
                bus_req = 1'b1;
                if (owner_r == DATA) begin
                    bus_wr       = data_wr;
                    bus_size     = data_size;
                    bus_addr     = data_addr;
                    bus_wdata    = data_wdata;
                    data_addr_ok = bus_addr_ok;
                end else begin
                    bus_size     = SIZE_WORD;
                    bus_addr     = inst_addr;
                    inst_addr_ok = bus_addr_ok;
                end
            end
            WAIT: begin
                if (bus_data_ok && (owner_r == DATA)) begin
                    data_data_ok = 1'b1;
                    data_rdata   = bus_rdata;
                end else if (bus_data_ok) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = bus_rdata;
                end else begin
                    data_data_ok = 1'b0;
                end
            end
            default: begin
                bus_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: the stimulus thread plays both
// requesters and the bus slave and queues expected address phases and data
// returns; a negedge monitor pops and compares whenever the DUT accepts an
// address or presents data_ok.
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    typedef struct {
        logic        is_inst;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } addr_exp_t;

    typedef struct {
        logic        is_inst;
        logic [31:0] rdata;
    } data_exp_t;

    addr_exp_t exp_addr_q[$];
    data_exp_t exp_data_q[$];

    int chk_cnt = 0;
    int err_cnt = 0;

    sram_bus_arbiter #(.FAIR_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_inst(input logic [31:0] addr, input logic [31:0] rdata, input logic with_data);
        addr_exp_t a;
        data_exp_t d;
        a.is_inst = 1'b1; a.wr = 1'b0; a.size = 2'd2; a.addr = addr; a.wdata = 32'h0;
        exp_addr_q.push_back(a);
        if (with_data) begin
            d.is_inst = 1'b1; d.rdata = rdata;
            exp_data_q.push_back(d);
        end
    endtask

    task automatic push_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        addr_exp_t a;
        data_exp_t d;
        a.is_inst = 1'b0; a.wr = wr; a.size = size; a.addr = addr; a.wdata = wdata;
        exp_addr_q.push_back(a);
        d.is_inst = 1'b0; d.rdata = rdata;
        exp_data_q.push_back(d);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_bus_fields"}, {29'd0, bus_wr, bus_size}, 32'd0);
        check({tag, "_bus_addr"}, bus_addr, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check({tag, "_oks"}, {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
        check({tag, "_rdata"}, inst_rdata | data_rdata, 32'd0);
        check({tag, "_state"}, {30'd0, dut.state_r}, {30'd0, IDLE});
    endtask

    // Bus slave for one transaction, entered in the cycle the request is seen in IDLE.
    task automatic bus_slave(input int addr_wait, input int data_wait, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic drop_inst, input logic drop_data);
        tick();
        for (int i = 0; i < addr_wait; i++) begin
            bus_addr_ok = 1'b0;
            @(negedge clk);
            check("stall_bus_req", {31'd0, bus_req}, 32'd1);
            check("stall_bus_addr", bus_addr, exp_addr);
            check("stall_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            check("stall_state", {30'd0, dut.state_r}, {30'd0, ADDR});
            tick();
        end
        bus_addr_ok = 1'b1;
        @(negedge clk);
        check("addr_bus_req", {31'd0, bus_req}, 32'd1);
        check("addr_bus_addr", bus_addr, exp_addr);
        tick();
        bus_addr_ok = 1'b0;
        if (drop_inst) inst_req = 1'b0;
        if (drop_data) data_req = 1'b0;
        for (int i = 0; i < data_wait; i++) begin
            @(negedge clk);
            check("wait_bus_req", {31'd0, bus_req}, 32'd0);
            check("wait_state", {30'd0, dut.state_r}, {30'd0, WAIT});
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        @(negedge clk);
        check("data_ok_seen", {31'd0, inst_data_ok | data_data_ok}, 32'd1);
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
    endtask

    // Monitor: compare every address accept and data return against the scoreboard.
    always @(negedge clk) begin
        addr_exp_t a;
        data_exp_t d;
        check("mutex_addr_ok", {31'd0, inst_addr_ok & data_addr_ok}, 32'd0);
        check("mutex_data_ok", {31'd0, inst_data_ok & data_data_ok}, 32'd0);
        if (bus_req && bus_addr_ok) begin
            if (exp_addr_q.size() == 0) begin
                chk_cnt++; err_cnt++;
                $display("FAIL unexpected_accept: addr 0x%08h accepted with no expectation at %0t", bus_addr, $time);
            end else begin
                a = exp_addr_q.pop_front();
                check("accept_owner_ok", {30'd0, inst_addr_ok, data_addr_ok}, a.is_inst ? 32'd2 : 32'd1);
                check("accept_wr_size", {29'd0, bus_wr, bus_size}, {29'd0, a.wr, a.size});
                check("accept_addr", bus_addr, a.addr);
                check("accept_wdata", bus_wdata, a.wdata);
            end
        end
        if (inst_data_ok || data_data_ok) begin
            if (exp_data_q.size() == 0) begin
                chk_cnt++; err_cnt++;
                $display("FAIL unexpected_data_ok: inst %0b data %0b with no expectation at %0t", inst_data_ok, data_data_ok, $time);
            end else begin
                d = exp_data_q.pop_front();
                check("data_ok_owner", {30'd0, inst_data_ok, data_data_ok}, d.is_inst ? 32'd2 : 32'd1);
                check("owner_rdata", d.is_inst ? inst_rdata : data_rdata, d.rdata);
                check("other_rdata", d.is_inst ? data_rdata : inst_rdata, 32'd0);
            end
        end else begin
            check("idle_rdata", inst_rdata | data_rdata, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seq_inst [6];
        logic [31:0] rd;
        rst = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

        // Reset state.
        tick(); tick();
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_owner", {31'd0, dut.owner_r}, {31'd0, INST});
        tick();
        rst = 1'b1;
        tick();

        // Inst read only: addr_ok cycle 1, data_ok cycle 3, IDLE cycle 4.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        push_inst(32'hBFC0_0000, 32'h3C08_0001, 1'b1);
        bus_slave(0, 1, 32'h3C08_0001, 32'hBFC0_0000, 1'b1, 1'b0);
        @(negedge clk);
        check_idle_outputs("inst_read_end");
        tick();

        // Simultaneous requests: byte store wins, inst follows after data_data_ok.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_0010; data_wdata = 32'h0000_00AB;
        push_data(1'b1, 2'd0, 32'h8000_0010, 32'h0000_00AB, 32'h0);
        push_inst(32'hBFC0_0100, 32'h1111_2222, 1'b1);
        bus_slave(0, 0, 32'h0, 32'h8000_0010, 1'b0, 1'b1);
        bus_slave(0, 0, 32'h1111_2222, 32'hBFC0_0100, 1'b1, 1'b0);
        @(negedge clk);
        check_idle_outputs("simul_end");
        tick();

        // Delayed address accept: five stall cycles in ADDR.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0020; data_wdata = 32'h0;
        push_data(1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'hCAFE_F00D);
        bus_slave(5, 0, 32'hCAFE_F00D, 32'h8000_0020, 1'b0, 1'b1);

        // Spurious handshakes in IDLE.
        bus_data_ok = 1'b1; bus_addr_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("spur_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("spur_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        tick();
        bus_data_ok = 1'b0; bus_addr_ok = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        check("spur_state", {30'd0, dut.state_r}, {30'd0, IDLE});
        tick();

        // Reset in WAIT: abandon the fetch, ignore the late bus_data_ok.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
        push_inst(32'hBFC0_0200, 32'h0, 1'b0);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        check("rstwait_state", {30'd0, dut.state_r}, {30'd0, WAIT});
        #1 rst = 1'b0;
        #1 check_idle_outputs("rstwait_async");
        tick();
        rst = 1'b1;
        bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rstwait_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("rstwait_idle", {30'd0, dut.state_r}, {30'd0, IDLE});
        tick();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;

        // Fairness: both requesters held high across six grants.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`ifdef ARB_FAIR_EN
        seq_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        seq_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0100; data_wdata = 32'h0;
        for (int k = 0; k < 6; k++) begin
            rd = 32'h1000_0000 + 32'(k);
            if (seq_inst[k]) begin
                push_inst(32'hBFC0_0300, rd, 1'b1);
                bus_slave(0, 0, rd, 32'hBFC0_0300, k == 5, k == 5);
            end else begin
                push_data(1'b0, 2'd2, 32'h8000_0100, 32'h0, rd);
                bus_slave(0, 0, rd, 32'h8000_0100, k == 5, k == 5);
            end
        end
        @(negedge clk);
        check_idle_outputs("fair_end");
        tick(); tick();

        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
